// File: rtl/issue_unit.sv
// rtl/issue_unit.sv - in-order issue queue resolving operands against rename status
// Buffers decoded instructions and issues them with operand values or producer tags.
module issue_unit #(
  parameter int ROB_WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_type,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic                 in_use_imm,
  input  logic [31:0]          in_imm,
  input  logic [ROB_WIDTH-1:0] in_rob_id,
  input  logic [31:0]          in_tja,
  input  logic [31:0]          in_fja,
  input  logic                 rs_full,
  output logic                 dec_ready,
  output logic [4:0]           issue_type,
  output logic [ROB_WIDTH-1:0] rob_id,
  output logic [31:0]          tja,
  output logic [31:0]          fja,
  output logic                 has_dep_j,
  output logic [ROB_WIDTH-1:0] dep_j,
  output logic [31:0]          val_j,
  output logic                 has_dep_k,
  output logic [ROB_WIDTH-1:0] dep_k,
  output logic [31:0]          val_k,
  input  logic                 rs_ready,
  input  logic [ROB_WIDTH-1:0] rs_rob_id,
  input  logic [31:0]          rs_value,
  input  logic                 lsb_ready,
  input  logic [ROB_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]          lsb_value,
  input  logic                 commit_valid,
  input  logic [4:0]           commit_rd,
  input  logic [ROB_WIDTH-1:0] commit_rob_id
);
  localparam int ROB_SIZE = 1 << ROB_WIDTH;
  localparam int RES_W = ROB_WIDTH + 33;

  logic [4:0]           q_type [4];
  logic [4:0]           q_rd [4];
  logic [4:0]           q_rs1 [4];
  logic [4:0]           q_rs2 [4];
  logic                 q_use_imm [4];
  logic [31:0]          q_imm [4];
  logic [ROB_WIDTH-1:0] q_rob_id [4];
  logic [31:0]          q_tja [4];
  logic [31:0]          q_fja [4];
  logic [1:0]           head;
  logic [1:0]           tail;
  logic [2:0]           count;

  logic                 stat_busy [32];
  logic [ROB_WIDTH-1:0] stat_tag [32];
  logic [31:0]          rf [32];
  logic                 rb_valid [ROB_SIZE];
  logic [31:0]          rb_value [ROB_SIZE];

  logic                 active;
  logic                 enq;
  logic [4:0]           src_j;
  logic [4:0]           src_k;
  logic [ROB_WIDTH-1:0] tag_j;
  logic [ROB_WIDTH-1:0] tag_k;
  logic [RES_W-1:0]     res_j;
  logic [RES_W-1:0]     res_k;

  assign active    = rst_in && rdy_in && !clear;
  assign in_ready  = (count != 3'd4) && active;
  assign dec_ready = (count != 3'd0) && !rs_full && active;
  assign enq       = in_valid && in_ready;

  // Result is packed as {has_dep, dep, val}; a live broadcast beats the buffered copy.
  function automatic logic [RES_W-1:0] resolve(
    input logic [4:0]           src,
    input logic                 busy,
    input logic [ROB_WIDTH-1:0] tag,
    input logic [31:0]          rf_val,
    input logic                 buf_valid,
    input logic [31:0]          buf_val,
    input logic                 rs_hit,
    input logic                 lsb_hit,
    input logic [31:0]          rs_val,
    input logic [31:0]          lsb_val
  );
    logic [RES_W-1:0] r;
    r = '0;
    if (src == 5'd0)  r = '0;
    else if (!busy)   r = {1'b0, {ROB_WIDTH{1'b0}}, rf_val};
    else if (rs_hit)  r = {1'b0, {ROB_WIDTH{1'b0}}, rs_val};
    else if (lsb_hit) r = {1'b0, {ROB_WIDTH{1'b0}}, lsb_val};
    else if (buf_valid) r = {1'b0, {ROB_WIDTH{1'b0}}, buf_val};
    else              r = {1'b1, tag, 32'd0};
    return r;
  endfunction

  assign src_j = q_rs1[head];
  assign src_k = q_rs2[head];
  assign tag_j = stat_tag[src_j];
  assign tag_k = stat_tag[src_k];

  assign res_j = resolve(src_j, stat_busy[src_j], tag_j, rf[src_j], rb_valid[tag_j],
                         rb_value[tag_j], rs_ready && (rs_rob_id == tag_j),
                         lsb_ready && (lsb_rob_id == tag_j), rs_value, lsb_value);
  assign res_k = resolve(src_k, stat_busy[src_k], tag_k, rf[src_k], rb_valid[tag_k],
                         rb_value[tag_k], rs_ready && (rs_rob_id == tag_k),
                         lsb_ready && (lsb_rob_id == tag_k), rs_value, lsb_value);

  assign issue_type = q_type[head];
  assign rob_id     = q_rob_id[head];
  assign tja        = q_tja[head];
  assign fja        = q_fja[head];
  assign has_dep_j  = res_j[RES_W-1];
  assign dep_j      = res_j[RES_W-2:32];
  assign val_j      = res_j[31:0];
  assign has_dep_k  = q_use_imm[head] ? 1'b0 : res_k[RES_W-1];
  assign dep_k      = q_use_imm[head] ? '0 : res_k[RES_W-2:32];
  assign val_k      = q_use_imm[head] ? q_imm[head] : res_k[31:0];

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < 32; i++) begin
        stat_busy[i] <= 1'b0;
        stat_tag[i]  <= '0;
        rf[i]        <= '0;
      end
      for (int i = 0; i < ROB_SIZE; i++) begin
        rb_valid[i] <= 1'b0;
        rb_value[i] <= '0;
      end
    end else if (rdy_in) begin
      if (clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        for (int i = 0; i < 32; i++) stat_busy[i] <= 1'b0;
        for (int i = 0; i < ROB_SIZE; i++) rb_valid[i] <= 1'b0;
      end else begin
        if (enq) begin
          q_type[tail]    <= in_type;
          q_rd[tail]      <= in_rd;
          q_rs1[tail]     <= in_rs1;
          q_rs2[tail]     <= in_rs2;
          q_use_imm[tail] <= in_use_imm;
          q_imm[tail]     <= in_imm;
          q_rob_id[tail]  <= in_rob_id;
          q_tja[tail]     <= in_tja;
          q_fja[tail]     <= in_fja;
          tail            <= tail + 2'd1;
        end
        if (dec_ready) head <= head + 2'd1;
        count <= count + {2'b0, enq} - {2'b0, dec_ready};

        if (rs_ready) begin
          rb_valid[rs_rob_id] <= 1'b1;
          rb_value[rs_rob_id] <= rs_value;
        end
        if (lsb_ready) begin
          rb_valid[lsb_rob_id] <= 1'b1;
          rb_value[lsb_rob_id] <= lsb_value;
        end
        if (dec_ready) rb_valid[q_rob_id[head]] <= 1'b0;

        if (commit_valid) begin
          if (commit_rd != 5'd0) rf[commit_rd] <= rb_value[commit_rob_id];
          if (stat_tag[commit_rd] == commit_rob_id) stat_busy[commit_rd] <= 1'b0;
        end
        // Placed last so a same-cycle rename of the committing register survives.
        if (dec_ready && (q_rd[head] != 5'd0)) begin
          stat_busy[q_rd[head]] <= 1'b1;
          stat_tag[q_rd[head]]  <= q_rob_id[head];
        end
      end
    end
  end
endmodule

// File: tb/tb_issue_unit.sv
// tb/tb_issue_unit.sv - randomized scoreboard bench for issue_unit
// A queue-based reference model predicts each issue; a monitor compares on dec_ready.
module tb_issue_unit;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, in_valid, in_ready, in_use_imm, rs_full, dec_ready;
  logic [4:0]  in_type, in_rd, in_rs1, in_rs2, issue_type, commit_rd;
  logic [31:0] in_imm, in_tja, in_fja, tja, fja, val_j, val_k, rs_value, lsb_value;
  logic [2:0]  in_rob_id, rob_id, dep_j, dep_k, rs_rob_id, lsb_rob_id, commit_rob_id;
  logic        has_dep_j, has_dep_k, rs_ready, lsb_ready, commit_valid;

  issue_unit #(.ROB_WIDTH(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_rob_id(in_rob_id), .in_tja(in_tja), .in_fja(in_fja), .rs_full(rs_full),
    .dec_ready(dec_ready), .issue_type(issue_type), .rob_id(rob_id), .tja(tja), .fja(fja),
    .has_dep_j(has_dep_j), .dep_j(dep_j), .val_j(val_j),
    .has_dep_k(has_dep_k), .dep_k(dep_k), .val_k(val_k),
    .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_rob_id(commit_rob_id)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [4:0] ty, rd, rs1, rs2;
    logic use_imm;
    logic [31:0] imm, tj, fj;
    logic [2:0] rob;
  } ins_t;

  typedef struct {
    int cyc;
    logic [4:0] ty;
    logic [2:0] rob, dj, dk;
    logic [31:0] tj, fj, vj, vk;
    logic hj, hk;
  } exp_t;

  ins_t        mq[$];
  exp_t        expq[$];
  int          ren[32];
  logic [31:0] rf_m[32];
  logic        rbv_m[8];
  logic [31:0] rbval_m[8];
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic model_reset(input bit zero_rf);
    mq.delete();
    for (int i = 0; i < 32; i++) begin
      ren[i] = -1;
      if (zero_rf) rf_m[i] = 32'd0;
    end
    for (int i = 0; i < 8; i++) rbv_m[i] = 1'b0;
  endtask

  task automatic resolve(input logic [4:0] r, output logic h, output logic [2:0] d,
                         output logic [31:0] v);
    int t;
    h = 1'b0; d = 3'd0; v = 32'd0;
    if (r == 5'd0) return;
    if (ren[r] < 0) begin
      v = rf_m[r];
      return;
    end
    t = ren[r];
    if (rs_ready && int'(rs_rob_id) == t) v = rs_value;
    else if (lsb_ready && int'(lsb_rob_id) == t) v = lsb_value;
    else if (rbv_m[t]) v = rbval_m[t];
    else begin
      h = 1'b1;
      d = 3'(t);
    end
  endtask

  task automatic model_cycle();
    bit act, ex_in_ready, ex_issue, ex_enq;
    ins_t h, n;
    exp_t e;
    logic [31:0] cval;
    act         = rst_in && rdy_in && !clear;
    ex_in_ready = act && (mq.size() < 4);
    ex_issue    = act && (mq.size() > 0) && !rs_full;
    ex_enq      = ex_in_ready && in_valid;
    check("in_ready", 64'(in_ready), 64'(ex_in_ready));
    if (ex_issue) begin
      h = mq[0];
      e.cyc = cyc; e.ty = h.ty; e.rob = h.rob; e.tj = h.tj; e.fj = h.fj;
      resolve(h.rs1, e.hj, e.dj, e.vj);
      if (h.use_imm) begin
        e.hk = 1'b0; e.dk = 3'd0; e.vk = h.imm;
      end else resolve(h.rs2, e.hk, e.dk, e.vk);
      expq.push_back(e);
    end
    if (!rst_in) model_reset(1'b1);
    else if (rdy_in && clear) model_reset(1'b0);
    else if (rdy_in) begin
      cval = rbval_m[commit_rob_id];
      if (ex_issue) h = mq.pop_front();
      if (ex_enq) begin
        n.ty = in_type; n.rd = in_rd; n.rs1 = in_rs1; n.rs2 = in_rs2;
        n.use_imm = in_use_imm; n.imm = in_imm; n.rob = in_rob_id;
        n.tj = in_tja; n.fj = in_fja;
        mq.push_back(n);
      end
      if (rs_ready) begin rbv_m[rs_rob_id] = 1'b1; rbval_m[rs_rob_id] = rs_value; end
      if (lsb_ready) begin rbv_m[lsb_rob_id] = 1'b1; rbval_m[lsb_rob_id] = lsb_value; end
      if (ex_issue) rbv_m[h.rob] = 1'b0;
      if (commit_valid) begin
        if (commit_rd != 5'd0) rf_m[commit_rd] = cval;
        if (ren[commit_rd] == int'(commit_rob_id)) ren[commit_rd] = -1;
      end
      if (ex_issue && h.rd != 5'd0) ren[h.rd] = int'(h.rob);
    end
  endtask

  task automatic drive_random(input int c);
    int full_pct;
    logic [2:0] t;
    full_pct = ((c / 80) % 2 == 1) ? 90 : 20;
    rst_in     = !(c < 3 || (c >= 1500 && c < 1502));
    rdy_in     = ($urandom % 10) != 0;
    clear      = ($urandom % 40) == 0;
    in_valid   = ($urandom % 4) != 0;
    in_type    = 5'($urandom);
    in_rd      = 5'($urandom % 8);
    in_rs1     = 5'($urandom % 8);
    in_rs2     = 5'($urandom % 8);
    in_use_imm = ($urandom % 3) == 0;
    in_imm     = $urandom;
    in_rob_id  = 3'($urandom);
    in_tja     = $urandom;
    in_fja     = $urandom;
    rs_full    = int'($urandom % 100) < full_pct;
    rs_ready   = ($urandom % 3) == 0;
    rs_rob_id  = 3'($urandom);
    rs_value   = $urandom;
    lsb_ready  = ($urandom % 3) == 0;
    lsb_rob_id = 3'($urandom);
    lsb_value  = $urandom;
    if (rs_ready && lsb_ready && rs_rob_id == lsb_rob_id) lsb_ready = 1'b0;
    // Commit only tags whose buffered value the model knows.
    t = 3'($urandom);
    commit_rob_id = t;
    commit_valid  = rbv_m[t] && (($urandom % 3) == 0);
    commit_rd     = 5'($urandom % 8);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (dec_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_issue", 64'(dec_ready), 64'd0);
        end else begin
          e = expq.pop_front();
          check("issue_cycle", 64'(cyc), 64'(e.cyc));
          check("type", 64'(issue_type), 64'(e.ty));
          check("rob_id", 64'(rob_id), 64'(e.rob));
          check("tja", 64'(tja), 64'(e.tj));
          check("fja", 64'(fja), 64'(e.fj));
          check("has_dep_j", 64'(has_dep_j), 64'(e.hj));
          check("dep_j", 64'(dep_j), 64'(e.dj));
          check("val_j", 64'(val_j), 64'(e.vj));
          check("has_dep_k", 64'(has_dep_k), 64'(e.hk));
          check("dep_k", 64'(dep_k), 64'(e.dk));
          check("val_k", 64'(val_k), 64'(e.vk));
        end
      end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
        e = expq.pop_front();
        check("missing_issue", 64'(dec_ready), 64'd1);
      end
    end
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b0; clear = 1'b0; in_valid = 1'b0; in_type = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_use_imm = 1'b0; in_imm = '0;
    in_rob_id = '0; in_tja = '0; in_fja = '0; rs_full = 1'b0;
    rs_ready = 1'b0; rs_rob_id = '0; rs_value = '0;
    lsb_ready = 1'b0; lsb_rob_id = '0; lsb_value = '0;
    commit_valid = 1'b0; commit_rd = '0; commit_rob_id = '0;
    for (int i = 0; i < 8; i++) rbval_m[i] = 32'd0;
    model_reset(1'b1);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_in);
      #1;
      cyc = c;
      drive_random(c);
      #1;
      model_cycle();
    end
    @(negedge clk_in);
    #1;
    check("scoreboard_drained", 64'(expq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/issue_unit.md
ISSUE_UNIT -- requirements
Module: issue_unit
Interface
REQ-001 ROB_WIDTH, default 3, ROB tag width; the ROB and result buffer hold 2^ROB_WIDTH entries.
REQ-002 clk_in  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_in  input  1  synchronous active-low reset.
REQ-004 rdy_in  input  1  global enable; low pauses the block.
REQ-005 clear  input  1  mispredict flush.
REQ-006 in_valid  input  1  decoded instruction valid.
REQ-007 in_ready  output  1  queue can accept an instruction this cycle.
REQ-008 in_type  input  5  op code: [4] branch, [3] funct7 bit, [2:0] funct3.
REQ-009 in_rd  input  5  destination register.
REQ-010 in_rs1  input  5  source j register.
REQ-011 in_rs2  input  5  source k register.
REQ-012 in_use_imm  input  1  operand k taken from in_imm.
REQ-013 in_imm  input  32  immediate.
REQ-014 in_rob_id  input  ROB_WIDTH  ROB entry allocated to the instruction.
REQ-015 in_tja  input  32  branch taken target.
REQ-016 in_fja  input  32  branch not-taken target.
REQ-017 rs_full  input  1  reservation station has no idle slot.
REQ-018 dec_ready  output  1  issue strobe to the reservation station.
REQ-019 type  output  5  issued op code.
REQ-020 rob_id  output  ROB_WIDTH  issued destination tag.
REQ-021 tja  output  32  issued taken target.
REQ-022 fja  output  32  issued not-taken target.
REQ-023 has_dep_j  output  1  operand j still pending.
REQ-024 dep_j  output  ROB_WIDTH  tag that produces operand j.
REQ-025 val_j  output  32  operand j value.
REQ-026 has_dep_k  output  1  operand k still pending.
REQ-027 dep_k  output  ROB_WIDTH  tag that produces operand k.
REQ-028 val_k  output  32  operand k value.
REQ-029 rs_ready  input  1  ALU broadcast valid.
REQ-030 rs_rob_id  input  ROB_WIDTH  ALU broadcast tag.
REQ-031 rs_value  input  32  ALU broadcast value.
REQ-032 lsb_ready  input  1  load/store broadcast valid.
REQ-033 lsb_rob_id  input  ROB_WIDTH  load/store broadcast tag.
REQ-034 lsb_value  input  32  load/store broadcast value.
REQ-035 commit_valid  input  1  ROB commits the entry at its head.
REQ-036 commit_rd  input  5  destination register of the committing entry.
REQ-037 commit_rob_id  input  ROB_WIDTH  tag of the committing entry.
Function
REQ-038 Queue: the instruction queue SHALL be a 4-entry FIFO with no bypass.
- in_ready = !full && rdy_in && rst_in && !clear.
- An instruction enqueues when in_valid && in_ready.
- Earliest issue is the cycle after enqueue.
REQ-039 Issue: dec_ready SHALL be combinational.
- dec_ready = head valid && !rs_full && rdy_in && rst_in && !clear.
- type, rob_id, tja and fja come from the queue head.
- The head pops on the rising edge where dec_ready is high; at most one issue per cycle, in FIFO order.
REQ-040 Operand resolution, applied to j (rs1) and to k (rs2):
- Source register x0: val 0, has_dep 0.
- Register status idle: val = register file value.
- Register status busy with tag T, checked in this priority:
  - rs_ready && rs_rob_id==T: val = rs_value.
  - lsb_ready && lsb_rob_id==T: val = lsb_value.
  - result buffer valid[T]: val = buffered value.
  - Otherwise: has_dep 1, dep = T, val 0.
- in_use_imm: val_k = imm, has_dep_k 0, dep_k 0.
- dep outputs are 0 whenever has_dep is 0.
REQ-041 Register status: 32 entries, each a busy bit and a tag.
- Issue with rd!=0 sets busy and tag = rob_id.
- Commit clears busy only when the stored tag == commit_rob_id.
- When issue and commit hit the same register in one cycle, issue wins.
- An operand read uses the pre-edge status, so rs1==rd sees the older producer.
REQ-042 Register file and result buffer:
- Register file: 32 x 32; x0 reads 0.
- commit_valid && commit_rd!=0 writes the result buffer value at commit_rob_id into the register file.
- Result buffer: 2^ROB_WIDTH entries of value and valid bit.
  - rs or lsb broadcast sets valid and value at the broadcast tag.
  - Issue clears valid at rob_id, and this wins over a broadcast to the same tag.
REQ-043 clear with rdy_in high: FIFO emptied, all status busy bits cleared, all result buffer valid bits cleared, register file kept, same-cycle enqueue and commit ignored. rdy_in low: all state held, dec_ready 0, in_ready 0.
Reset
REQ-044 rst_in low at a rising edge SHALL:
- empty the FIFO;
- set every status entry idle;
- invalidate every result buffer entry;
- zero the register file.
While rst_in is low, dec_ready and in_ready SHALL read 0.
Verification
REQ-045 Reset, enqueue ADDI x1,x0,5 (use_imm, imm 5, rob 0), rs_full 0 -> next cycle: dec_ready 1, val_j 0, val_k 5, both has_dep 0, rob_id 0; x1 then busy with tag 0.
REQ-046 ADD x2,x1,x1 as rob 1 with no broadcast -> has_dep_j 1, dep_j 0, has_dep_k 1, dep_k 0; repeat with rs_ready, rs_rob_id 0, rs_value 5 in the issue cycle -> both has_dep 0, val_j 5, val_k 5.
REQ-047 rs_full 1 with 4 instructions queued -> dec_ready 0, in_ready 0, fifth in_valid not accepted; rs_full then 0 -> four issues on consecutive cycles in order; rdy_in low mid-drain -> issue freezes with no loss.
REQ-048 Broadcast rob 0 value 5, x1 renamed to rob 2, commit rob 0 rd x1 -> register file x1 = 5 and x1 stays busy with tag 2; commit rob 2 -> a later read of x1 gives has_dep 0.
REQ-049 clear with 3 queued and x3 busy -> next cycle dec_ready 0, in_ready 1; a new read of x3 gives the register file value with has_dep 0.
